// File: rtl/fpu_op_dispatch.sv
// fpu_op_dispatch: issues one FPU op at a time to 15 functional units and captures the result (optional timeout via FPU_DISPATCH_TIMEOUT_EN)
module fpu_op_dispatch #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [3:0]  op_sel,
    input  logic [63:0] operand_a,
    input  logic [63:0] operand_b,
    output logic [63:0] unit_a,
    output logic [63:0] unit_b,
    output logic [14:0] unit_start,
    input  logic [14:0] unit_done,
    output logic [3:0]  mux_sel,
    input  logic [63:0] mux_x,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [63:0] result,
    output logic        err
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
    state_t state, nxt;
    logic [15:0] done_ext;
    logic done, timeout, fire;
    assign done_ext = {1'b0, unit_done};
    assign done = done_ext[mux_sel];
    assign fire = op_valid && op_ready;
    assign op_ready = rst_n && state == IDLE;
    assign res_valid = state == HOLD;
    assign unit_start = state == ISSUE ? 15'd1 << mux_sel : 15'd0;
`ifdef FPU_DISPATCH_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt;
    assign timeout = cnt == CW'(TIMEOUT_CYCLES - 1);
    // wait-cycle counter: cleared while issuing, counts every WAIT cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else if (state == ISSUE) cnt <= '0;
        else if (state == WAIT) cnt <= cnt + 1'b1;
    end
`else
    assign timeout = 1'b0;
`endif
    // next-state decode
    always_comb begin
        nxt = state;
        case (state)
            IDLE:  nxt = op_valid ? (op_sel == 4'hF ? HOLD : ISSUE) : IDLE;
            ISSUE: nxt = WAIT;
            WAIT:  nxt = done || timeout ? HOLD : WAIT;
            HOLD:  nxt = res_ready ? IDLE : HOLD;
            default: nxt = IDLE;
        endcase
    end
    // state, operand/select capture and result capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            mux_sel <= '0;
            unit_a  <= '0;
            unit_b  <= '0;
            result  <= '0;
            err     <= 1'b0;
        end else begin
            state <= nxt;
            if (fire) begin
                mux_sel <= op_sel;
                unit_a  <= operand_a;
                unit_b  <= operand_b;
                if (op_sel == 4'hF) begin
                    result <= '0;
                    err    <= 1'b1;
                end
            end
            if (state == WAIT && done) begin
                result <= mux_x;
                err    <= 1'b0;
            end else if (state == WAIT && timeout) begin
                result <= '0;
                err    <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fpu_op_dispatch.sv
// tb_fpu_op_dispatch: directed self-checking bench for fpu_op_dispatch
module tb_fpu_op_dispatch;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        op_ready;
    logic [3:0]  op_sel = '0;
    logic [63:0] operand_a = '0;
    logic [63:0] operand_b = '0;
    logic [63:0] unit_a, unit_b;
    logic [14:0] unit_start;
    logic [14:0] unit_done = '0;
    logic [3:0]  mux_sel;
    logic [63:0] mux_x = '0;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [63:0] result;
    logic        err;
    int vecs = 0;
    int errs = 0;
    fpu_op_dispatch #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_ready(op_ready),
        .op_sel(op_sel), .operand_a(operand_a), .operand_b(operand_b),
        .unit_a(unit_a), .unit_b(unit_b), .unit_start(unit_start),
        .unit_done(unit_done), .mux_sel(mux_sel), .mux_x(mux_x),
        .res_valid(res_valid), .res_ready(res_ready), .result(result), .err(err)
    );
    always #5 clk = ~clk;
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    initial begin
        #2;
        check("rst op_ready", op_ready, 0);
        check("rst res_valid", res_valid, 0);
        check("rst unit_start", unit_start, 0);
        check("rst result", result, 0);
        check("rst err", err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("idle op_ready", op_ready, 1);
        op_valid = 1; op_sel = 3; operand_a = 5; operand_b = 7; mux_x = 64'd12;
        tick();
        op_valid = 0;
        check("t1 issue start", unit_start, 15'h0008);
        check("t1 mux_sel", mux_sel, 3);
        check("t1 unit_a", unit_a, 5);
        check("t1 unit_b", unit_b, 7);
        check("t1 issue op_ready", op_ready, 0);
        check("t1 issue res_valid", res_valid, 0);
        tick();
        check("t1 wait start", unit_start, 0);
        check("t1 wait res_valid", res_valid, 0);
        unit_done = 15'h0008;
        tick();
        unit_done = 0;
        check("t1 res_valid", res_valid, 1);
        check("t1 result", result, 12);
        check("t1 err", err, 0);
        check("t1 hold start", unit_start, 0);
        mux_x = 64'd99;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t4 hold res_valid", res_valid, 1);
            check("t4 hold result", result, 12);
            check("t4 hold op_ready", op_ready, 0);
        end
        res_ready = 1;
        tick();
        res_ready = 0;
        check("t4 release res_valid", res_valid, 0);
        check("t4 release op_ready", op_ready, 1);
        op_valid = 1; op_sel = 4'hF; operand_a = 64'h55;
        tick();
        op_valid = 0;
        check("t2 res_valid", res_valid, 1);
        check("t2 result", result, 0);
        check("t2 err", err, 1);
        check("t2 start", unit_start, 0);
        check("t2 op_ready", op_ready, 0);
        res_ready = 1;
        tick();
        res_ready = 0;
        check("t2 back idle", op_ready, 1);
        op_valid = 1; op_sel = 9; operand_a = 64'hA; operand_b = 64'hB;
        unit_done = 15'h0004; mux_x = 64'hDEAD_BEEF_0000_0009;
        tick();
        op_valid = 0;
        check("t3 start", unit_start, 15'h0200);
        tick();
        for (int i = 0; i < 10; i++) begin
            check("t3 wait res_valid", res_valid, 0);
            check("t3 wait start", unit_start, 0);
            tick();
        end
        unit_done = 15'h0204;
        tick();
        unit_done = 0;
        check("t3 res_valid", res_valid, 1);
        check("t3 result", result, 64'hDEAD_BEEF_0000_0009);
        check("t3 err", err, 0);
        res_ready = 1;
        tick();
        res_ready = 0;
        op_valid = 1; op_sel = 1; operand_a = 64'd11; operand_b = 64'd13; mux_x = 64'd77;
        tick();
        op_valid = 0;
        tick();
        check("t5 wait unit_a", unit_a, 11);
        #2 rst_n = 0;
        #1;
        check("t5 rst unit_a", unit_a, 0);
        check("t5 rst unit_b", unit_b, 0);
        check("t5 rst mux_sel", mux_sel, 0);
        check("t5 rst op_ready", op_ready, 0);
        check("t5 rst start", unit_start, 0);
        unit_done = 15'h0002;
        tick();
        tick();
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5 after res_valid", res_valid, 0);
            check("t5 after op_ready", op_ready, 1);
            check("t5 after start", unit_start, 0);
        end
        unit_done = 0;
        op_valid = 1; op_sel = 5; mux_x = 64'h1234;
        tick();
        op_valid = 0;
        tick();
`ifdef FPU_DISPATCH_TIMEOUT_EN
        for (int i = 0; i < 7; i++) begin
            tick();
            check("t6 wait res_valid", res_valid, 0);
        end
        tick();
        check("t6 to res_valid", res_valid, 1);
        check("t6 to result", result, 0);
        check("t6 to err", err, 1);
`else
        for (int i = 0; i < 20; i++) begin
            tick();
            check("t6 wait res_valid", res_valid, 0);
        end
        unit_done = 15'h0020;
        tick();
        unit_done = 0;
        check("t6 res_valid", res_valid, 1);
        check("t6 result", result, 64'h1234);
        check("t6 err", err, 0);
`endif
        res_ready = 1;
        tick();
        res_ready = 0;
        check("t6 back idle", op_ready, 1);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
